adder_serial_n_bit: RTL

//   Multi-cycle N-bit adder/subtractor. It is the parametrised successor of the 1-bit full adder.

---
 rtl/adder_serial_n_bit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/adder_serial_n_bit.sv
// Multi-cycle N-bit adder/subtractor. Operands are consumed LSB-first,
// CHUNK bits per clock, through a registered carry. A valid/ready handshake
// guards both the operand side and the result side.
module adder_serial_n_bit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  // Reject geometries where the chunks do not tile the operand exactly.
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_serial_n_bit: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [KW-1:0]    k_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] r_chunk_s;
  logic             carry_next_s;
  logic             carry_msb_s;
  logic             last_s;
  logic [WIDTH-1:0] res_next_s;

  assign in_ready = (state_r == IDLE);

  // Chunk adder: adds the current slice of A and B plus the stored carry and
  // merges the partial sum into the running result.
  always_comb begin
    a_chunk_s = a_r[int'(k_r) * CHUNK +: CHUNK];
    b_chunk_s = b_r[int'(k_r) * CHUNK +: CHUNK];
    {carry_next_s, r_chunk_s} = {1'b0, a_chunk_s} + {1'b0, b_chunk_s}
                                + {{CHUNK{1'b0}}, carry_r};
    // Carry into the chunk MSB recovered from its sum bit; on the last chunk
    // this is the carry into the operand MSB.
    carry_msb_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ r_chunk_s[CHUNK-1];
    res_next_s = res_r;
    res_next_s[int'(k_r) * CHUNK +: CHUNK] = r_chunk_s;
    last_s = (k_r == K_LAST);
  end

  // Control FSM and datapath registers: accept, run N chunks, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      carry_r   <= 1'b0;
      k_r       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1; the caller's carry-in is ignored.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : c_in;
            k_r     <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          carry_r <= carry_next_s;
          if (last_s) begin
            k_r       <= '0;
            sum       <= res_next_s;
            c_out     <= carry_next_s;
            overflow  <= carry_msb_s ^ carry_next_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          k_r       <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
